// File: rtl/sr_cmd_pkg.sv
// rtl/sr_cmd_pkg.sv - shared types and limits for the sr_cmd_seq sequencer
package sr_cmd_pkg;

    localparam int SR_CMD_CNT_W   = 4;
    localparam int SR_CMD_MAX_LEN = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } sr_cmd_state_t;

endpackage

// File: rtl/sr_cmd_timer.sv
// rtl/sr_cmd_timer.sv - loadable down-counter that flags when it has reached zero
module sr_cmd_timer
    import sr_cmd_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic [SR_CMD_CNT_W-1:0] load_val_i,
    input  logic                    dec_i,
    output logic                    done_o
);

    logic [SR_CMD_CNT_W-1:0] cnt_q;
    logic [SR_CMD_CNT_W-1:0] cnt_d;

    // Load wins over decrement; the count holds at zero instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sr_cmd_seq.sv
// rtl/sr_cmd_seq.sv - set/reset pulse sequencer for sr3; readback checker under SR_CMD_READBACK_EN
module sr_cmd_seq
    import sr_cmd_pkg::*;
#(
    parameter int PULSE_LEN = 1,
    parameter int GAP_LEN   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_set,
    output logic req_ready,
    output logic s,
    output logic r,
`ifdef SR_CMD_READBACK_EN
    input  logic q_fb,
    output logic mismatch,
`endif
    output logic busy
);

    if (PULSE_LEN < 1 || PULSE_LEN > SR_CMD_MAX_LEN) begin : g_bad_pulse
        $error("sr_cmd_seq: PULSE_LEN must be 1..15");
    end
    if (GAP_LEN < 0 || GAP_LEN > SR_CMD_MAX_LEN) begin : g_bad_gap
        $error("sr_cmd_seq: GAP_LEN must be 0..15");
    end
`ifdef SR_CMD_READBACK_EN
    if (GAP_LEN < 1) begin : g_bad_rb_gap
        $error("sr_cmd_seq: readback needs GAP_LEN >= 1");
    end
`endif

    localparam logic [SR_CMD_CNT_W-1:0] PULSE_LD = SR_CMD_CNT_W'(PULSE_LEN - 1);
    localparam logic [SR_CMD_CNT_W-1:0] GAP_LD   = (GAP_LEN > 0) ? SR_CMD_CNT_W'(GAP_LEN - 1) : '0;

    sr_cmd_state_t           state_q, state_d;
    logic                    set_q, set_d;
    logic                    s_q, s_d;
    logic                    r_q, r_d;
    logic                    tmr_load;
    logic [SR_CMD_CNT_W-1:0] tmr_load_val;
    logic                    tmr_dec;
    logic                    tmr_done;

    sr_cmd_timer u_timer (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .done_o     (tmr_done)
    );

    // Next state, timer control and the registered s/r drive derived from where we go next.
    always_comb begin
        state_d      = state_q;
        set_d        = set_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d      = DRIVE;
                    set_d        = req_set;
                    tmr_load     = 1'b1;
                    tmr_load_val = PULSE_LD;
                end
            end
            DRIVE: begin
                if (!tmr_done) begin
                    tmr_dec = 1'b1;
                end else if (GAP_LEN == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d      = GAP;
                    tmr_load     = 1'b1;
                    tmr_load_val = GAP_LD;
                end
            end
            GAP: begin
                if (!tmr_done) begin
                    tmr_dec = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        s_d = (state_d == DRIVE) && set_d;
        r_d = (state_d == DRIVE) && !set_d;
    end

    // State, latched command type and output drive registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            set_q   <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            s_q     <= s_d;
            r_q     <= r_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign s         = s_q;
    assign r         = r_q;

`ifdef SR_CMD_READBACK_EN
    logic chk_q, chk_d;
    logic mismatch_q, mismatch_d;

    // chk_q marks the first gap cycle, when sr3 has already absorbed the pulse.
    always_comb begin
        chk_d      = (state_q == DRIVE) && (state_d == GAP);
        mismatch_d = mismatch_q | (chk_q && (q_fb != set_q));
    end

    // Readback check flag and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_q      <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            chk_q      <= chk_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_sr_cmd_seq.sv
// tb/tb_sr_cmd_seq.sv - self-checking bench for sr_cmd_seq, three parameter sets side by side
module tb_sr_cmd_seq;

    localparam int P0 = 1;
    localparam int G0 = 2;
    localparam int P1 = 5;
    localparam int G1 = 2;
    localparam int P2 = 2;
`ifdef SR_CMD_READBACK_EN
    localparam int G2 = 1;
`else
    localparam int G2 = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [2:0] valid;
    logic [2:0] setb;
    logic [2:0] ready;
    logic [2:0] s;
    logic [2:0] r;
    logic [2:0] busy;
    logic [2:0] q_m = 3'b000;
    logic       cmp_en;
    int         vectors;
    int         miscompares;

`ifdef SR_CMD_READBACK_EN
    logic [2:0] force0;
    logic [2:0] qfb;
    logic [2:0] mm;
    assign qfb = q_m & ~force0;
`endif

    sr_cmd_seq #(.PULSE_LEN(P0), .GAP_LEN(G0)) u_dut0 (
        .clk(clk), .reset(rst_n), .req_valid(valid[0]), .req_set(setb[0]),
        .req_ready(ready[0]), .s(s[0]), .r(r[0]),
`ifdef SR_CMD_READBACK_EN
        .q_fb(qfb[0]), .mismatch(mm[0]),
`endif
        .busy(busy[0])
    );

    sr_cmd_seq #(.PULSE_LEN(P1), .GAP_LEN(G1)) u_dut1 (
        .clk(clk), .reset(rst_n), .req_valid(valid[1]), .req_set(setb[1]),
        .req_ready(ready[1]), .s(s[1]), .r(r[1]),
`ifdef SR_CMD_READBACK_EN
        .q_fb(qfb[1]), .mismatch(mm[1]),
`endif
        .busy(busy[1])
    );

    sr_cmd_seq #(.PULSE_LEN(P2), .GAP_LEN(G2)) u_dut2 (
        .clk(clk), .reset(rst_n), .req_valid(valid[2]), .req_set(setb[2]),
        .req_ready(ready[2]), .s(s[2]), .r(r[2]),
`ifdef SR_CMD_READBACK_EN
        .q_fb(qfb[2]), .mismatch(mm[2]),
`endif
        .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int plen(input int i);
        return (i == 0) ? P0 : ((i == 1) ? P1 : P2);
    endfunction

    function automatic int glen(input int i);
        return (i == 0) ? G0 : ((i == 1) ? G1 : G2);
    endfunction

    // Model: t = cycles since acceptance (0 = idle); pulse occupies t=1..P, gap t=P+1..P+G.
    int   t[3];
    logic kind[3];
    logic mm_m[3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                t[i]    <= 0;
                kind[i] <= 1'b0;
                mm_m[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (t[i] == 0) begin
                    if (valid[i]) begin
                        t[i]    <= 1;
                        kind[i] <= setb[i];
                    end
                end else if (t[i] < plen(i) + glen(i)) begin
                    t[i] <= t[i] + 1;
                end else begin
                    t[i] <= 0;
                end
`ifdef SR_CMD_READBACK_EN
                if (t[i] == plen(i) + 1 && qfb[i] != kind[i]) mm_m[i] <= 1'b1;
`endif
            end
        end
    end

    // Downstream sr3 flip-flops fed by each sequencer.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (s[i]) q_m[i] <= 1'b1;
            else if (r[i]) q_m[i] <= 1'b0;
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all three sequencers against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                chk1($sformatf("ready%0d", i), ready[i], t[i] == 0);
                chk1($sformatf("busy%0d", i), busy[i], t[i] != 0);
                chk1($sformatf("s%0d", i), s[i], (t[i] >= 1) && (t[i] <= plen(i)) && kind[i]);
                chk1($sformatf("r%0d", i), r[i], (t[i] >= 1) && (t[i] <= plen(i)) && !kind[i]);
                chk1($sformatf("excl%0d", i), s[i] & r[i], 1'b0);
`ifdef SR_CMD_READBACK_EN
                chk1($sformatf("mismatch%0d", i), mm[i], mm_m[i]);
`endif
            end
        end
    end

    task automatic send(input int i, input logic k, output time ta);
        int n;
        n          = 0;
        ta         = 0;
        valid[i]   = 1'b1;
        setb[i]    = k;
        forever begin
            @(negedge clk);
            if (ready[i]) break;
            n++;
            if (n > 50) break;
        end
        if (n > 50) begin
            chkn($sformatf("accept_timeout%0d", i), n, 0);
        end else begin
            @(posedge clk);
            ta = $time;
        end
        #1;
        valid[i] = 1'b0;
    endtask

    initial begin
        time ta, tb;
        int  sc, rc, nr, n;
        logic [8:0] pat, exp_pat;
        vectors     = 0;
        miscompares = 0;
        cmp_en      = 1'b0;
        rst_n       = 1'b0;
        valid       = 3'b000;
        setb        = 3'b000;
`ifdef SR_CMD_READBACK_EN
        force0      = 3'b000;
`endif
        repeat (3) @(negedge clk);
        chk1("rst_s", s[0], 1'b0);
        chk1("rst_r", r[0], 1'b0);
        chk1("rst_busy", busy[0], 1'b0);
        chk1("rst_ready", ready[0], 1'b1);
`ifdef SR_CMD_READBACK_EN
        chk1("rst_mismatch", mm[0], 1'b0);
`endif
        cmp_en = 1'b1;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single set with defaults.
        send(0, 1'b1, ta);
        sc = 0; rc = 0; nr = 0;
        repeat (6) begin
            @(negedge clk);
            sc += int'(s[0]);
            rc += int'(r[0]);
            nr += int'(!ready[0]);
        end
        chkn("single_s_cycles", sc, 1);
        chkn("single_r_cycles", rc, 0);
        chkn("single_notready_cycles", nr, 3);
        chk1("single_q", q_m[0], 1'b1);

        // Back-to-back set then clear.
        send(0, 1'b1, ta);
        send(0, 1'b0, tb);
        chkn("b2b_spacing", int'(tb - ta), 40);
        repeat (6) @(negedge clk);
        chk1("b2b_q", q_m[0], 1'b0);

        // Reset in the third cycle of a 5-cycle set pulse.
        send(1, 1'b1, ta);
        repeat (3) @(negedge clk);
        chk1("mid_s_before", s[1], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("mid_s_after", s[1], 1'b0);
        chk1("mid_busy_after", busy[1], 1'b0);
        chk1("mid_ready_after", ready[1], 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(1, 1'b0, ta);
        sc = 0; rc = 0;
        repeat (10) begin
            @(negedge clk);
            sc += int'(s[1]);
            rc += int'(r[1]);
        end
        chkn("mid_r_cycles", rc, 5);
        chkn("mid_s_cycles", sc, 0);

        // Continuous clear requests on the short-gap instance.
        valid[2] = 1'b1;
        setb[2]  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!r[2] && n < 20);
        chk1("zg_started", r[2], 1'b1);
        pat = '0;
        exp_pat = '0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            pat[8-k]     = r[2];
            exp_pat[8-k] = (k % (P2 + G2 + 1)) < P2;
        end
        chkn("zg_pattern", int'(pat), int'(exp_pat));
`ifndef SR_CMD_READBACK_EN
        chkn("zg_pattern_lit", int'(pat), int'(9'b110110110));
`endif
        #1 valid[2] = 1'b0;
        repeat (6) @(negedge clk);

`ifdef SR_CMD_READBACK_EN
        // Readback: q_fb held low after a set command.
        force0[0] = 1'b1;
        send(0, 1'b1, ta);
        @(negedge clk);
        chk1("rb_before1", mm[0], 1'b0);
        @(negedge clk);
        chk1("rb_before2", mm[0], 1'b0);
        @(negedge clk);
        chk1("rb_raised", mm[0], 1'b1);
        force0[0] = 1'b0;
        send(0, 1'b0, ta);
        send(0, 1'b1, ta);
        repeat (6) @(negedge clk);
        chk1("rb_sticky", mm[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("rb_reset", mm[0], 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
`endif

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sr_cmd_seq.md
# sr_cmd_seq

Command sequencer that sits directly upstream of the `sr3` set/reset flip-flop and drives its `s`/`r` inputs. It accepts set/clear requests over a valid/ready handshake and converts each into a clean, registered `s` or `r` pulse of programmable length, followed by a guard gap. `s` and `r` are never asserted together. An optional readback checker compares the flip-flop's `q` against the expected value after every command.

## Interface
Parameters:
- `PULSE_LEN`, default 1: cycles `s` or `r` is held high per command; legal range 1..15.
- `GAP_LEN`, default 2: idle cycles after each pulse before the next request is accepted; legal range 0..15.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `req_valid`  in  1  request present.
- `req_set`  in  1  request type: 1 = set (drive `s`), 0 = clear (drive `r`); qualified by `req_valid`.
- `req_ready`  out  1  sequencer can accept a request this cycle.
- `s`  out  1  set drive to the flip-flop; registered.
- `r`  out  1  reset drive to the flip-flop; registered.
- `busy`  out  1  high in every state except IDLE.
- `q_fb`  in  1  flip-flop output feedback; present only with `SR_CMD_READBACK_EN`.
- `mismatch`  out  1  sticky readback error; present only with `SR_CMD_READBACK_EN`.

## Operation
- FSM states:
  - IDLE: `req_ready`=1; on `req_valid & req_ready`, latch `req_set` and go to DRIVE.
  - DRIVE: the selected output is high for `PULSE_LEN` cycles; go to GAP, or to IDLE if `GAP_LEN`=0.
  - GAP: `s`=`r`=0 for `GAP_LEN` cycles, then go to IDLE.
- `req_ready` = (state == IDLE), combinational from the state register.
- `busy` = !(state == IDLE).
- Requests presented while `req_ready`=0 are ignored. The requester holds `req_valid` until it is accepted.
- One down-counter, width 4, loaded with `PULSE_LEN-1` on entry to DRIVE and with `GAP_LEN-1` on entry to GAP. The state advances when the counter reaches 0. No wrap-around occurs.
- `s` and `r` are mutually exclusive by construction. The latched type selects exactly one of them.
- Asserting `reset` at any time, including mid-pulse, immediately forces:
  - state = IDLE, counter = 0;
  - `s` = 0, `r` = 0, `busy` = 0, `mismatch` = 0.
- `req_ready` reads 1 while in reset. No acceptance occurs until the first rising edge after `reset` deasserts.
- Out-of-range parameters are an elaboration error, reported with `$error` in a generate check.

## Timing
- Request accepted at edge E0:
  - `s`/`r` high from just after E0 through edge E(`PULSE_LEN`).
  - `req_ready` low from just after E0 and high again after edge E(`PULSE_LEN`+`GAP_LEN`).
- Minimum command spacing is `PULSE_LEN`+`GAP_LEN`+1 cycles; with defaults, one command every 4 cycles.
- Latency from acceptance to `s`/`r` visible: 1 register stage.
- The flip-flop is registered, so `q_fb` reflects a command one cycle after the first pulse cycle.

## Configuration
- `SR_CMD_READBACK_EN` defined:
  - `q_fb` and `mismatch` ports exist.
  - `q_fb` is sampled at the edge that ends the first cycle after DRIVE completes.
  - Expected value: 1 for set, 0 for clear.
  - Any difference sets `mismatch`, which stays high until reset.
  - Requires `GAP_LEN` ≥ 1; otherwise elaboration error.
- `SR_CMD_READBACK_EN` not defined: the ports, sampling logic and flag are absent, and all other behaviour is identical.

## Structure
- Shared package `sr_cmd_pkg` contains:
  - state enum `sr_cmd_state_t` (IDLE, DRIVE, GAP);
  - constant `SR_CMD_CNT_W` = 4;
  - limits `SR_CMD_MAX_LEN` = 15.
- Sub-module `sr_cmd_timer`: loadable 4-bit down-counter with a `done` output, instantiated once.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles → `s`=`r`=`busy`=0, `req_ready`=1, `mismatch`=0.
- **Single set, defaults:** `req_valid`=1, `req_set`=1 for one cycle → `s`=1 for exactly 1 cycle, `r`=0 throughout, `req_ready` low 3 cycles, `q` of a downstream `sr3` goes 1.
- **Back-to-back requests:** set then clear, with `req_valid` held high → `s` pulse, 2-cycle gap, then `r` pulse; accepts spaced 4 cycles apart; `s` & `r` never both 1.
- **Mid-pulse reset:** `PULSE_LEN`=5, assert `reset` in pulse cycle 3 → `s` drops to 0 immediately; after release, a new clear request produces a full 5-cycle `r` pulse.
- **Zero gap:** `GAP_LEN`=0, `PULSE_LEN`=2, continuous clear requests → `r` high 2 cycles and low 1 cycle (IDLE), repeating every 3 cycles.
- **Readback (macro on):** force `q_fb`=0 after a set command → `mismatch` rises at the check edge and stays 1 through further correct commands until reset.
